// File: rtl/branch_resolve_pipe_pkg.sv
// Shared definitions for the branch resolution pipe: op codes, S1 control payload, sign-extend helper.
package br_pkg;

  typedef logic [2:0] br_op_t;

  localparam br_op_t BR_EQZ = 3'd0;
  localparam br_op_t BR_NEZ = 3'd1;
  localparam br_op_t BR_LTZ = 3'd2;
  localparam br_op_t BR_GEZ = 3'd3;
  localparam br_op_t BR_JMP = 3'd4;
  localparam br_op_t BR_JR  = 3'd5;

  // Width-independent part of the S1 payload; the wide fields live in the top.
  typedef struct packed {
    br_op_t op;
    logic   pred_tkn;
  } br_s1_ctl_t;

  // Sign-extend the low w bits of v to 32 bits; callers truncate to their width.
  function automatic logic [31:0] sext(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = v;
    for (int unsigned i = 0; i < 32; i++)
      if (i >= w) r[i] = v[w-1];
    return r;
  endfunction

endpackage

// File: rtl/branch_resolve_pipe_if.sv
// Request/result handshake bundle for branch_resolve_pipe.
interface branch_resolve_pipe_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IMM_W = 11
);
  import br_pkg::*;

  logic             in_valid;
  logic             in_ready;
  br_op_t           in_op;
  logic [WIDTH-1:0] in_rs;
  logic [WIDTH-1:0] in_pc;
  logic [IMM_W-1:0] in_imm;
  logic             in_pred_tkn;
  logic [WIDTH-1:0] in_pred_tgt;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic [WIDTH-1:0] out_tgt;
  logic             out_mispred;
  logic             out_err;

  modport master (
    output in_valid, in_op, in_rs, in_pc, in_imm, in_pred_tkn, in_pred_tgt, out_ready,
    input  in_ready, out_valid, out_taken, out_tgt, out_mispred, out_err
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_pc, in_imm, in_pred_tkn, in_pred_tgt, out_ready,
    output in_ready, out_valid, out_taken, out_tgt, out_mispred, out_err
  );
endinterface

// File: rtl/branch_resolve_pipe_stage.sv
// Generic elastic register stage: valid/ready, flush, async active-low reset.
module br_pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/branch_resolve_pipe.sv
// Two-stage pipelined branch/jump resolution unit.
// Optional BRANCH_STATS_EN adds saturating branch/taken/mispredict counters.
module branch_resolve_pipe
  import br_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned IMM_W       = 11,
  parameter int unsigned INSTR_BYTES = 2,
  parameter int unsigned STAT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  branch_resolve_pipe_if.slave bus
`ifdef BRANCH_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [STAT_W-1:0]  stat_br,
  output logic [STAT_W-1:0]  stat_tkn,
  output logic [STAT_W-1:0]  stat_mis
`endif
);

  typedef struct packed {
    br_s1_ctl_t       ctl;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pred_tgt;
    logic [IMM_W-1:0] imm;
  } s1_t;

  typedef struct packed {
    logic             taken;
    logic             mispred;
    logic             err;
    logic [WIDTH-1:0] tgt;
  } s2_t;

  s1_t              s1_in, s1_q;
  s2_t              s2_in, s2_q;
  logic             s1_v, s2_ready;
  logic [WIDTH-1:0] imm_x, fall;

  always_comb begin
    s1_in.ctl.op       = bus.in_op;
    s1_in.ctl.pred_tkn = bus.in_pred_tkn;
    s1_in.rs           = bus.in_rs;
    s1_in.pc           = bus.in_pc;
    s1_in.pred_tgt     = bus.in_pred_tgt;
    s1_in.imm          = bus.in_imm;
  end

  br_pipe_stage #(.W($bits(s1_t))) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (s1_in),
    .out_valid (s1_v),
    .out_ready (s2_ready),
    .out_data  (s1_q)
  );

  always_comb begin
    imm_x = WIDTH'(sext(32'(s1_q.imm), IMM_W));
    fall  = s1_q.pc + WIDTH'(INSTR_BYTES);
    s2_in = '0;
    s2_in.tgt = s1_q.pc + imm_x;
    case (s1_q.ctl.op)
      BR_EQZ:  s2_in.taken = (s1_q.rs == '0);
      BR_NEZ:  s2_in.taken = (s1_q.rs != '0);
      BR_LTZ:  s2_in.taken = s1_q.rs[WIDTH-1];
      BR_GEZ:  s2_in.taken = !s1_q.rs[WIDTH-1];
      BR_JMP:  s2_in.taken = 1'b1;
      BR_JR: begin
        s2_in.taken = 1'b1;
        s2_in.tgt   = s1_q.rs + imm_x;
      end
      default: s2_in.err = 1'b1;
    endcase
    if (!s2_in.taken) s2_in.tgt = fall;
    s2_in.mispred = !s2_in.err &&
                    ((s2_in.taken != s1_q.ctl.pred_tkn) ||
                     (s2_in.taken && s1_q.ctl.pred_tkn && (s2_in.tgt != s1_q.pred_tgt)));
  end

  br_pipe_stage #(.W($bits(s2_t))) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (s1_v),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (s2_q)
  );

  assign bus.out_taken   = s2_q.taken;
  assign bus.out_mispred = s2_q.mispred;
  assign bus.out_err     = s2_q.err;
  assign bus.out_tgt     = s2_q.tgt;

`ifdef BRANCH_STATS_EN
  logic hs;
  // A result leaving in a flush cycle belongs to the killed stream and is not counted.
  assign hs = bus.out_valid && bus.out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br  <= '0;
      stat_tkn <= '0;
      stat_mis <= '0;
    end else if (stat_clr) begin
      stat_br  <= '0;
      stat_tkn <= '0;
      stat_mis <= '0;
    end else if (hs) begin
      if (!s2_q.err && (stat_br != '1))  stat_br  <= stat_br + 1'b1;
      if (s2_q.taken && (stat_tkn != '1)) stat_tkn <= stat_tkn + 1'b1;
      if (s2_q.mispred && (stat_mis != '1)) stat_mis <= stat_mis + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Randomized self-checking bench for branch_resolve_pipe against a queue-based reference model.
module tb_branch_resolve_pipe;

  typedef struct packed {
    logic        taken;
    logic        mispred;
    logic        err;
    logic [15:0] tgt;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  res_t q[$];
  bit   hold_pend = 0;
  res_t hold_val;
  bit   last_rdy, last_acc;

  always #5 clk = ~clk;

  branch_resolve_pipe_if #(.WIDTH(16), .IMM_W(11)) bus ();

`ifdef BRANCH_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_br, stat_tkn, stat_mis;
  logic [1:0]  stat_br2, stat_tkn2, stat_mis2;
  int          m_br = 0, m_tk = 0, m_mis = 0;

  branch_resolve_pipe_if #(.WIDTH(16), .IMM_W(11)) bus2 ();
  assign bus2.in_valid    = bus.in_valid;
  assign bus2.in_op       = bus.in_op;
  assign bus2.in_rs       = bus.in_rs;
  assign bus2.in_pc       = bus.in_pc;
  assign bus2.in_imm      = bus.in_imm;
  assign bus2.in_pred_tkn = bus.in_pred_tkn;
  assign bus2.in_pred_tgt = bus.in_pred_tgt;
  assign bus2.out_ready   = bus.out_ready;

  branch_resolve_pipe #(.WIDTH(16), .IMM_W(11), .INSTR_BYTES(2), .STAT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus2),
    .stat_clr(stat_clr), .stat_br(stat_br2), .stat_tkn(stat_tkn2), .stat_mis(stat_mis2)
  );
`endif

  branch_resolve_pipe #(.WIDTH(16), .IMM_W(11), .INSTR_BYTES(2), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
`ifdef BRANCH_STATS_EN
    , .stat_clr(stat_clr), .stat_br(stat_br), .stat_tkn(stat_tkn), .stat_mis(stat_mis)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: resolve a branch from its architectural definition with integer arithmetic.
  function automatic res_t model(input logic [2:0] op, input logic [15:0] rs, input logic [15:0] pc,
                                 input logic [10:0] imm, input bit pt, input logic [15:0] pg);
    res_t r;
    int   simm, t;
    bit   tk;
    simm = imm[10] ? int'(imm) - 2048 : int'(imm);
    case (op)
      3'd0:       tk = (rs == 0);
      3'd1:       tk = (rs != 0);
      3'd2:       tk = (rs >= 16'h8000);
      3'd3:       tk = (rs <  16'h8000);
      3'd4, 3'd5: tk = 1;
      default:    tk = 0;
    endcase
    t = (op == 3'd5) ? int'(rs) + simm : int'(pc) + simm;
    if (!tk) t = int'(pc) + 2;
    t = ((t % 65536) + 65536) % 65536;
    r.taken   = tk;
    r.err     = (op > 3'd5);
    r.tgt     = t[15:0];
    r.mispred = !r.err && ((tk != pt) || (tk && pt && r.tgt != pg));
    return r;
  endfunction

  // Called just after a negedge drive; evaluates the cycle and returns at the next negedge.
  task automatic tick();
    res_t cur, e;
    #1;
    cur = {bus.out_taken, bus.out_mispred, bus.out_err, bus.out_tgt};
    if (hold_pend) chk("hold", cur, hold_val);
    chk("in_ready", bus.in_ready, !(q.size() == 2 && !bus.out_ready));
    last_rdy = bus.in_ready;
    last_acc = bus.in_valid && bus.in_ready && !flush;
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("result", cur, e);
`ifdef BRANCH_STATS_EN
        if (!e.err && m_br < 65535) m_br++;
        if (e.taken && m_tk < 65535) m_tk++;
        if (e.mispred && m_mis < 65535) m_mis++;
`endif
      end
    end
`ifdef BRANCH_STATS_EN
    if (stat_clr) begin m_br = 0; m_tk = 0; m_mis = 0; end
`endif
    hold_pend = bus.out_valid && !bus.out_ready && !flush;
    hold_val  = cur;
    if (flush) q.delete();
    else if (last_acc)
      q.push_back(model(bus.in_op, bus.in_rs, bus.in_pc, bus.in_imm, bus.in_pred_tkn, bus.in_pred_tgt));
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] rs, input logic [15:0] pc,
                       input logic [10:0] imm, input bit pt, input logic [15:0] pg);
    bus.in_op = op; bus.in_rs = rs; bus.in_pc = pc; bus.in_imm = imm;
    bus.in_pred_tkn = pt; bus.in_pred_tgt = pg;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 0; bus.out_ready = 1; flush = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One request with fixed expectations, checking the two-cycle latency on the way.
  task automatic dir(input string tag, input logic [2:0] op, input logic [15:0] rs,
                     input logic [15:0] pc, input logic [10:0] imm, input bit pt,
                     input logic [15:0] pg, input res_t exp);
    drive(op, rs, pc, imm, pt, pg);
    bus.in_valid = 1; bus.out_ready = 1; flush = 0;
    tick();
    bus.in_valid = 0;
    chk({tag, "_lat1"}, bus.out_valid, 0);
    tick();
    chk({tag, "_lat2"}, bus.out_valid, 1);
    chk(tag, {bus.out_taken, bus.out_mispred, bus.out_err, bus.out_tgt}, exp);
    tick();
  endtask

  initial begin
    int idx;
    res_t r;
    rst_n = 0; flush = 0;
    bus.in_valid = 0; bus.out_ready = 0;
    drive(0, 0, 0, 0, 0, 0);
`ifdef BRANCH_STATS_EN
    stat_clr = 0;
`endif
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_outputs", {bus.out_taken, bus.out_mispred, bus.out_err, bus.out_tgt}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    #1 chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);

    dir("eqz",   3'd0, 16'h0000, 16'h0100, 11'h010, 1, 16'h0110, {1'b1, 1'b0, 1'b0, 16'h0110});
    dir("ltz",   3'd2, 16'h7FFF, 16'h0200, 11'h000, 1, 16'h0300, {1'b0, 1'b1, 1'b0, 16'h0202});
    dir("jr",    3'd5, 16'hFFF0, 16'h0300, 11'h020, 1, 16'h0010, {1'b1, 1'b0, 1'b0, 16'h0010});
    dir("ill",   3'd7, 16'h1234, 16'h0400, 11'h055, 0, 16'h0000, {1'b0, 1'b0, 1'b1, 16'h0402});
    dir("jmpneg",3'd4, 16'h0000, 16'h0004, 11'h7F8, 1, 16'hFFFC, {1'b1, 1'b0, 1'b0, 16'hFFFC});

    // Back-to-back requests with the consumer stalled for three cycles.
    idx = 0;
    bus.in_valid = 1; flush = 0;
    drive(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 11'($urandom), 1'($urandom), 16'($urandom));
    for (int c = 0; c < 12; c++) begin
      bus.out_ready = (c >= 3);
      bus.in_valid  = (idx < 4);
      tick();
      if (c == 2) chk("rdy_fall", last_rdy, 0);
      if (last_acc) begin
        idx++;
        drive(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 11'($urandom), 1'($urandom), 16'($urandom));
      end
    end
    chk("b2b_accepted", idx, 4);
    idle(4);
    chk("b2b_drained", q.size(), 0);

    // Flush with two in flight plus a third being offered.
    bus.out_ready = 0; bus.in_valid = 1;
    drive(3'd4, 0, 16'h1000, 11'h004, 0, 0); tick();
    drive(3'd4, 0, 16'h2000, 11'h004, 0, 0); tick();
    drive(3'd4, 0, 16'h3000, 11'h004, 0, 0); flush = 1; tick();
    flush = 0; bus.in_valid = 0; bus.out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      chk("flush_quiet", bus.out_valid, 0);
      tick();
    end

    // Asynchronous reset mid-stream.
    bus.in_valid = 1; drive(3'd0, 0, 16'h0500, 11'h002, 1, 16'h0502); tick(); tick();
    bus.in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_tgt", bus.out_tgt, 0);
    q.delete(); hold_pend = 0;
    @(negedge clk);
    rst_n = 1;
    #1 chk("arst_in_ready", bus.in_ready, 1);
    @(negedge clk);

`ifdef BRANCH_STATS_EN
    stat_clr = 1; idle(1); stat_clr = 0;
    dir("s_eqz", 3'd0, 16'h0000, 16'h0010, 11'h008, 1, 16'h0018, {1'b1, 1'b0, 1'b0, 16'h0018});
    dir("s_nez", 3'd1, 16'h0000, 16'h0020, 11'h008, 0, 16'h0000, {1'b0, 1'b0, 1'b0, 16'h0022});
    dir("s_jmp", 3'd4, 16'h0000, 16'h0030, 11'h010, 1, 16'h0040, {1'b1, 1'b0, 1'b0, 16'h0040});
    dir("s_gez", 3'd3, 16'h8000, 16'h0040, 11'h010, 1, 16'h0050, {1'b0, 1'b1, 1'b0, 16'h0042});
    dir("s_ltz", 3'd2, 16'h8000, 16'h0050, 11'h010, 0, 16'h0000, {1'b1, 1'b1, 1'b0, 16'h0060});
    idle(1);
    chk("stat_br", stat_br, 5);
    chk("stat_tkn", stat_tkn, 3);
    chk("stat_mis", stat_mis, 2);
    chk("stat_br_sat", stat_br2, 3);
    stat_clr = 1; idle(1); stat_clr = 0;
    chk("stat_clr", {stat_br, stat_tkn, stat_mis}, 0);
`endif

    // Randomized traffic with random stalls and occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      logic [2:0]  op;
      logic [15:0] rs, pc, pg;
      logic [10:0] imm;
      bit          pt;
      op  = 3'($urandom_range(0, 7));
      rs  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      pc  = 16'($urandom);
      imm = 11'($urandom);
      pt  = 1'($urandom);
      r   = model(op, rs, pc, imm, pt, 16'h0000);
      pg  = ($urandom_range(0, 1) == 0) ? r.tgt : 16'($urandom);
      drive(op, rs, pc, imm, pt, pg);
      flush = ($urandom_range(0, 99) < 3);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = flush ? 1'b0 : ($urandom_range(0, 9) < 7);
      tick();
    end
    idle(6);
    chk("final_drain", q.size(), 0);
`ifdef BRANCH_STATS_EN
    chk("rand_stat_br", stat_br, m_br);
    chk("rand_stat_tkn", stat_tkn, m_tk);
    chk("rand_stat_mis", stat_mis, m_mis);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
